// File: rtl/reg_writeback_ctrl_if.sv
// Signal bundle between the result producers / read ports and reg_writeback_ctrl.
// master drives results and read addresses; slave is the controller.
interface reg_writeback_ctrl_if;
  logic        alu_valid;
  logic [2:0]  alu_addr;
  logic [15:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [2:0]  rd0_addr;
  logic [2:0]  rd1_addr;
  logic        rd0_hazard;
  logic        rd1_hazard;
  logic        wr_en;
  logic [2:0]  wr0_addr;
  logic [15:0] wr0_data;
  logic        init_done;
  logic        err_drop;

  modport master (
    output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, rd0_addr, rd1_addr,
    input  ld_ready, rd0_hazard, rd1_hazard, wr_en, wr0_addr, wr0_data, init_done, err_drop
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, rd0_addr, rd1_addr,
    output ld_ready, rd0_hazard, rd1_hazard, wr_en, wr0_addr, wr0_data, init_done, err_drop
  );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// Write-port arbiter for the 8x16 register file: post-reset zero sweep, ALU-priority
// writeback, 2-entry load FIFO and read-after-write hazard flags.
module reg_writeback_ctrl (
  input logic             clk,
  input logic             rst,
  reg_writeback_ctrl_if.slave bus
);
  typedef enum logic {CLEAR, RUN} state_t;

  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic        wr_en_q, wr_en_n;
  logic [2:0]  wr_addr_q, wr_addr_n;
  logic [15:0] wr_data_q, wr_data_n;
  logic        init_q, init_n;
  logic        err_q, err_n;

  logic [2:0]  fifo_addr [2];
  logic [15:0] fifo_data [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic [1:0]  occ;
  logic        push, pop;
  logic        haz0, haz1;

  assign bus.ld_ready   = init_q && (count != 2'd2);
  assign push           = bus.ld_valid && bus.ld_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr0_addr   = wr_addr_q;
  assign bus.wr0_data   = wr_data_q;
  assign bus.init_done  = init_q;
  assign bus.err_drop   = err_q;
  assign bus.rd0_hazard = haz0;
  assign bus.rd1_hazard = haz1;

  // RUN is entered with the last clear write; init_done follows one cycle later,
  // and until then ALU results are still dropped.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr_q;
    wr_data_n = wr_data_q;
    init_n    = init_q;
    err_n     = err_q | (bus.alu_valid & ~init_q);
    pop       = 1'b0;
    unique case (state)
      CLEAR: begin
        wr_en_n   = 1'b1;
        wr_addr_n = idx;
        wr_data_n = '0;
        idx_n     = idx + 3'd1;
        if (idx == 3'd7) state_n = RUN;
      end
      RUN: begin
        if (!init_q) begin
          init_n = 1'b1;
        end else if (bus.alu_valid) begin
          wr_en_n   = 1'b1;
          wr_addr_n = bus.alu_addr;
          wr_data_n = bus.alu_data;
        end else if (count != 2'd0) begin
          pop       = 1'b1;
          wr_en_n   = 1'b1;
          wr_addr_n = fifo_addr[rd_ptr];
          wr_data_n = fifo_data[rd_ptr];
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      idx       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      init_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      wr_en_q   <= wr_en_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
      init_q    <= init_n;
      err_q     <= err_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= bus.ld_addr;
        fifo_data[wr_ptr] <= bus.ld_data;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Occupancy mask of the FIFO slots, used to qualify hazard address matches.
  always_comb begin
    unique case (count)
      2'd0:    occ = 2'b00;
      2'd1:    occ = rd_ptr ? 2'b10 : 2'b01;
      default: occ = 2'b11;
    endcase
  end

  always_comb begin
    haz0 = wr_en_q && (bus.rd0_addr == wr_addr_q);
    haz1 = wr_en_q && (bus.rd1_addr == wr_addr_q);
    for (int unsigned i = 0; i < 2; i++) begin
      if (occ[i] && (fifo_addr[i] == bus.rd0_addr)) haz0 = 1'b1;
      if (occ[i] && (fifo_addr[i] == bus.rd1_addr)) haz1 = 1'b1;
    end
  end
endmodule

// File: doc/reg_writeback_ctrl.md
# reg_writeback_ctrl

Write-side controller for the 8x16 register file. It merges two result producers onto the file's single write port (wr_en / wr0_addr / wr0_data): a single-cycle ALU result stream with priority, and a back-pressured load-result stream buffered in a 2-entry FIFO. After reset it sweeps zeros into r0..r7, because the register file itself has no reset. It also flags read-after-write hazards for the two read ports while writes are still pending.

## Interface
Parameters: none (file fixed at 8 x 16 bits).

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle; no back-pressure
- alu_addr  in  3  ALU destination register
- alu_data  in  16  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  load result accepted when ld_valid & ld_ready
- ld_addr  in  3  load destination register
- ld_data  in  16  load result
- rd0_addr  in  3  read-port-0 address (same net as register file)
- rd1_addr  in  3  read-port-1 address
- rd0_hazard  out  1  rd0_addr has a write not yet visible in the file
- rd1_hazard  out  1  same for rd1_addr
- wr_en  out  1  register-file write enable (registered)
- wr0_addr  out  3  register-file write address (registered)
- wr0_data  out  16  register-file write data (registered)
- init_done  out  1  clear sweep finished; block accepting results
- err_drop  out  1  sticky: an alu_valid was dropped before init_done

## Operation
- States: CLEAR (3-bit index 0..7) -> RUN. Reset enters CLEAR with index 0. There is no path back except reset.
- CLEAR: each cycle register wr_en=1, wr0_addr=index, wr0_data=0, then index++. After the index-7 write is issued, go to RUN and set init_done=1.
- In CLEAR: ld_ready=0. Any alu_valid is discarded and sets err_drop, which holds until reset.
- RUN, per-cycle write select, with priority top to bottom:
  - alu_valid=1: register wr_en=1, wr0_addr=alu_addr, wr0_data=alu_data. FIFO does not pop.
  - else FIFO non-empty: pop the head and register it on the write outputs with wr_en=1.
  - else: wr_en=0. wr0_addr and wr0_data hold their last values.
- Load FIFO: 2 entries, each {addr[2:0], data[15:0]}. Push on ld_valid & ld_ready.
  - ld_ready = init_done & (count < 2). It is combinational and does not depend on a same-cycle pop, so at count==2 ld_ready=0 even when popping.
  - A push and a pop in the same cycle leave count unchanged.
  - Loads never bypass the FIFO. An accepted load is always written at least 2 cycles after acceptance.
- Ordering:
  - Loads are written in acceptance order.
  - ALU writes may overtake queued loads.
  - Two pending writes to the same register are not merged. Program order is the producers' responsibility.
- Hazard, combinational: rdN_hazard=1 iff rdN_addr equals
  - wr0_addr while wr_en=1, or
  - the addr of any valid FIFO entry.
- Reset values: wr_en=0, wr0_addr=0, wr0_data=0, init_done=0, err_drop=0, FIFO count=0, index=0. Therefore ld_ready=0, and rd0_hazard / rd1_hazard follow the FIFO/wr_en state (0 at reset).

## Timing
- Let E1 be the first rising edge after rst deasserts.
  - E1..E8: clear writes to addresses 0..7.
  - E9: wr_en=0 and init_done=1.
  - The first alu_valid honoured is the one sampled at E10.
- ALU: alu_valid sampled at edge N -> wr_en/addr/data valid from N to N+1 -> file updated at N+1 -> readable after N+1.
- Load: accepted at edge N -> earliest pop at N+1, and only if alu_valid=0 then -> wr_en from N+1 to N+2.
- Continuous alu_valid starves the FIFO. ld_ready stays 0 once it is full; this is intended.
- rst asserted mid-operation:
  - All outputs go to reset values immediately.
  - FIFO contents are lost and in-flight writes are abandoned.
  - The clear sweep restarts after release.

## Test plan
- Reset release: wr_en=1 for exactly 8 cycles with wr0_addr 0,1,...,7 and data 0x0000; init_done rises at E9; a register-file read of r5 then gives 0x0000.
- alu_valid pulsed in cycle 3 of CLEAR: no write of that data appears and err_drop=1; err_drop stays 1 until rst.
- RUN, ld {addr 2, 0xBEEF} accepted, no ALU traffic: wr_en with addr 2 / 0xBEEF two edges later; rd0_addr=2 gives rd0_hazard=1 from acceptance until the write commits, then 0.
- Three back-to-back loads (addr 1,3,4) while alu_valid is held high 4 cycles (addr 6, data 0x1234..0x1237):
  - ld_ready drops after 2 accepts.
  - Four ALU writes to addr 6 come first.
  - Then loads 1 and 3.
  - Third load accepted once ld_ready returns, written last.
- Same-cycle push and pop at count 1: count stays 1 and ordering is preserved.
- rst asserted with 2 FIFO entries pending: wr_en=0 immediately, no load write ever appears, and the clear sweep repeats.
